dmem_arbiter: RTL and testbench

- Shares the single data-memory port of `memory` between two requesters: port 0 (CPU core load/store path) and port 1 (debug/program loader).
- Sits between the requesters and the memory's `dmem_*` pins. Grants one access per cycle and routes synchronous read data back to the issuing port.
- Port 1 can request exclusive ownership. The arbiter then drains in-flight reads and locks the core out until the request is released.

---
 rtl/dmem_arbiter.sv | 158 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the data-memory port: round-robin sharing,
// exclusive ownership for port 1, and read-data routing by tag.
`timescale 1ns/1ps
module dmem_arbiter #(
  parameter int READ_LATENCY = 1,
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [2:0]        funct3_0,
  input  logic [2:0]        funct3_1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  input  logic              excl_req,
  output logic              excl_gnt,
  output logic              mem_wren,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  output logic [2:0]        mem_funct3,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [1:0] ST_SHARED = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_EXCL   = 2'd2;

  logic [1:0]              state_q, state_d;
  logic                    last_q, last_d;
  logic                    excl_gnt_q;
  logic [READ_LATENCY-1:0] tag_vld_q, tag_port_q;
  logic [ADDR_W-1:0]       addr_q;
  logic [DATA_W-1:0]       wdata_q, rdata0_q, rdata1_q;
  logic [2:0]              funct3_q;
  logic                    grant, load_push, tags_empty;

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      case (state_q)
        ST_SHARED: begin
          if (req0 && req1) begin
            gnt0 = last_q;
            gnt1 = !last_q;
          end else begin
            gnt0 = req0;
            gnt1 = req1;
          end
        end
        ST_EXCL: gnt1 = req1;
        default: ;
      endcase
    end
  end

  assign grant     = gnt0 | gnt1;
  assign mem_wren  = (gnt0 & we0) | (gnt1 & we1);
  assign load_push = (gnt0 & ~we0) | (gnt1 & ~we1);

  always_comb begin
    mem_address = addr_q;
    mem_data_in = wdata_q;
    mem_funct3  = funct3_q;
    if (gnt1) begin
      mem_address = addr1;
      mem_data_in = wdata1;
      mem_funct3  = funct3_1;
    end else if (gnt0) begin
      mem_address = addr0;
      mem_data_in = wdata0;
      mem_funct3  = funct3_0;
    end
  end

  // The oldest tag lines up with the memory's read data for that grant.
  assign rvalid0    = tag_vld_q[READ_LATENCY-1] & ~tag_port_q[READ_LATENCY-1];
  assign rvalid1    = tag_vld_q[READ_LATENCY-1] &  tag_port_q[READ_LATENCY-1];
  assign rdata0     = rvalid0 ? mem_rdata : rdata0_q;
  assign rdata1     = rvalid1 ? mem_rdata : rdata1_q;
  assign tags_empty = ~|tag_vld_q;
  assign excl_gnt   = excl_gnt_q;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    if (gnt0) last_d = 1'b0;
    if (gnt1) last_d = 1'b1;
    case (state_q)
      ST_SHARED: if (excl_req) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (!excl_req)      state_d = ST_SHARED;
        else if (tags_empty) state_d = ST_EXCL;
      end
      ST_EXCL: begin
        if (!excl_req) begin
          state_d = ST_SHARED;
          last_d  = 1'b1;
        end
      end
      default: state_d = ST_SHARED;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_SHARED;
      last_q     <= 1'b1;
      excl_gnt_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      funct3_q   <= 3'b010;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      excl_gnt_q <= (state_d == ST_EXCL);
      if (grant) begin
        addr_q   <= mem_address;
        wdata_q  <= mem_data_in;
        funct3_q <= mem_funct3;
      end
      if (rvalid0) rdata0_q <= mem_rdata;
      if (rvalid1) rdata1_q <= mem_rdata;
    end
  end

  // NOTE: unlike a data array, the tag pipeline must be reset: a stale valid bit would fabricate an rvalid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_vld_q  <= '0;
      tag_port_q <= '0;
    end else begin
      tag_vld_q[0]  <= load_push;
      tag_port_q[0] <= gnt1;
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag_vld_q[i]  <= tag_vld_q[i-1];
        tag_port_q[i] <= tag_port_q[i-1];
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomised bench for dmem_arbiter: behavioural memory, arbitration model and
// a read-return scoreboard checked by an independent monitor.
`timescale 1ns/1ps
module tb_dmem_arbiter;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, we0, we1, excl_req;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic [2:0]  funct3_0, funct3_1;
  logic        gnt0, gnt1, rvalid0, rvalid1, excl_gnt, mem_wren;
  logic [31:0] rdata0, rdata1, mem_address, mem_data_in, mem_rdata;
  logic [2:0]  mem_funct3;

  dmem_arbiter #(.READ_LATENCY(LAT), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .funct3_0(funct3_0), .funct3_1(funct3_1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .excl_req(excl_req), .excl_gnt(excl_gnt),
    .mem_wren(mem_wren), .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_funct3(mem_funct3), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  // ---------------- memory device: synchronous read, LAT cycles ----------------
  logic [31:0] mem    [logic [31:0]];
  logic [31:0] shadow [logic [31:0]];
  logic [31:0] dly    [LAT];
  logic        cap_wr, cap_rd;
  logic [31:0] cap_a, cap_d;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : init_val(a);
  endfunction
  function automatic logic [31:0] shadow_rd(input logic [31:0] a);
    return shadow.exists(a) ? shadow[a] : init_val(a);
  endfunction

  always @(negedge clk) begin
    cap_wr = mem_wren;
    cap_rd = (gnt0 | gnt1) & ~mem_wren;
    cap_a  = mem_address;
    cap_d  = mem_data_in;
  end

  initial begin
    mem_rdata = '0;
    cap_wr = 1'b0;
    cap_rd = 1'b0;
    for (int i = 0; i < LAT; i++) dly[i] = '0;
    forever begin
      @(posedge clk);
      #1;
      if (cap_wr) mem[cap_a] = cap_d;
      for (int i = LAT - 1; i > 0; i--) dly[i] = dly[i-1];
      dly[0]    = cap_rd ? mem_rd(cap_a) : (32'hBAD0_0000 ^ $urandom);
      mem_rdata = dly[LAT-1];
    end
  end

  // ---------------- reference model: arbitration rules + scoreboard push ----------------
  typedef struct { bit port; logic [31:0] data; int due; } exp_t;
  typedef enum { M_SHARED, M_DRAIN, M_EXCL } mode_e;

  exp_t        exp_q[$];
  int          due_q[$];
  mode_e       mode;
  bit          prefer1;
  logic [31:0] held_a, held_d;
  logic [2:0]  held_f;

  always @(negedge clk) begin : model
    int          g;
    logic        w;
    logic [31:0] a, d;
    logic [2:0]  f;
    if (reset) begin
      check("rst_gnt", {gnt0, gnt1}, 2'b00);
      check("rst_excl_gnt", excl_gnt, 1'b0);
      check("rst_mem_wren", mem_wren, 1'b0);
      check("rst_mem_address", mem_address, 32'h0);
      check("rst_mem_data_in", mem_data_in, 32'h0);
      check("rst_mem_funct3", mem_funct3, 3'b010);
      mode    = M_SHARED;
      prefer1 = 1'b0;
      held_a  = '0;
      held_d  = '0;
      held_f  = 3'b010;
      exp_q.delete();
      due_q.delete();
    end else begin
      g = -1;
      if (mode == M_SHARED) begin
        if (req0 && req1) g = prefer1 ? 1 : 0;
        else if (req0)    g = 0;
        else if (req1)    g = 1;
      end else if (mode == M_EXCL && req1) begin
        g = 1;
      end
      check("gnt0", gnt0, g == 0);
      check("gnt1", gnt1, g == 1);
      check("excl_gnt", excl_gnt, mode == M_EXCL);
      if (g >= 0) begin
        w = (g == 1) ? we1 : we0;
        a = (g == 1) ? addr1 : addr0;
        d = (g == 1) ? wdata1 : wdata0;
        f = (g == 1) ? funct3_1 : funct3_0;
        check("mem_wren", mem_wren, w);
        check("mem_address", mem_address, a);
        check("mem_data_in", mem_data_in, d);
        check("mem_funct3", mem_funct3, f);
        held_a  = a;
        held_d  = d;
        held_f  = f;
        prefer1 = (g == 0);
        if (w) shadow[a] = d;
        else begin
          exp_q.push_back('{port: (g == 1), data: shadow_rd(a), due: cyc + LAT});
          due_q.push_back(cyc + LAT);
        end
      end else begin
        check("idle_mem_wren", mem_wren, 1'b0);
        check("hold_mem_address", mem_address, held_a);
        check("hold_mem_data_in", mem_data_in, held_d);
        check("hold_mem_funct3", mem_funct3, held_f);
      end
      while (due_q.size() != 0 && due_q[0] < cyc) void'(due_q.pop_front());
      case (mode)
        M_SHARED: if (excl_req) mode = M_DRAIN;
        M_DRAIN: begin
          if (!excl_req)              mode = M_SHARED;
          else if (due_q.size() == 0) mode = M_EXCL;
        end
        default: begin
          if (!excl_req) begin
            mode    = M_SHARED;
            prefer1 = 1'b0;
          end
        end
      endcase
    end
  end

  // ---------------- monitor: pops expected reads, checks rvalid/rdata ----------------
  logic [31:0] last_rd [2];

  always @(negedge clk) begin : monitor
    exp_t e;
    bit   due0, due1;
    if (reset) begin
      last_rd[0] = '0;
      last_rd[1] = '0;
      check("rst_rvalid", {rvalid0, rvalid1}, 2'b00);
      check("rst_rdata0", rdata0, 32'h0);
      check("rst_rdata1", rdata1, 32'h0);
    end else begin
      due0 = 1'b0;
      due1 = 1'b0;
      if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        if (e.port) due1 = 1'b1; else due0 = 1'b1;
        last_rd[e.port] = e.data;
      end
      check("rvalid0", rvalid0, due0);
      check("rvalid1", rvalid1, due1);
      check("rdata0", rdata0, last_rd[0]);
      check("rdata1", rdata1, last_rd[1]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input int p, input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [2:0] f);
    if (p == 0) begin
      req0 = r; we0 = w; addr0 = a; wdata0 = d; funct3_0 = f;
    end else begin
      req1 = r; we1 = w; addr1 = a; wdata1 = d; funct3_1 = f;
    end
  endtask

  task automatic idle(input int p);
    drive(p, 1'b0, 1'($urandom_range(0, 1)), $urandom, $urandom, 3'($urandom));
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Holds the request until a grant is seen on a rising edge (bounded wait).
  task automatic issue(input int p, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [2:0] f);
    logic g;
    g = 1'b0;
    drive(p, 1'b1, w, a, d, f);
    for (int k = 0; k < 200 && !g; k++) begin
      @(negedge clk);
      g = (p == 0) ? gnt0 : gnt1;
      @(posedge clk);
      #1;
    end
    if (!g) begin
      check(p == 0 ? "grant_wait_p0" : "grant_wait_p1", g, 1'b1);
      idle(p);
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    mem[a]    = d;
    shadow[a] = d;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, expected finish within time limit");
    $fatal(1);
  end

  initial begin
    logic g0, g1;
    reset    = 1'b1;
    excl_req = 1'b0;
    drive(0, 1'b1, 1'b0, 32'h40, 32'h1, 3'b000);
    drive(1, 1'b1, 1'b1, 32'h44, 32'h2, 3'b001);
    step(2);
    idle(0);
    idle(1);
    reset = 1'b0;

    // single load from port 0
    preload(32'h0000_0100, 32'hDEAD_BEEF);
    issue(0, 1'b0, 32'h0000_0100, 32'h0, 3'b010);
    idle(0);
    step(LAT + 2);

    // store from port 1
    issue(1, 1'b1, 32'h0000_0200, 32'h1234_5678, 3'b010);
    idle(1);
    step(LAT + 1);

    // contention: both ports load back to back
    fork
      begin
        for (int k = 0; k < 2; k++) issue(0, 1'b0, 32'h0000_0110 + 32'(k * 8), $urandom, 3'b010);
        idle(0);
      end
      begin
        issue(1, 1'b0, 32'h0000_0200, $urandom, 3'b010);
        issue(1, 1'b0, 32'h0000_0114, $urandom, 3'b100);
        idle(1);
      end
    join
    step(LAT + 1);

    // exclusive: drain a port-0 read, lock port 0 out, release
    issue(0, 1'b0, 32'h0000_0300, $urandom, 3'b010);
    excl_req = 1'b1;
    fork
      begin
        issue(0, 1'b0, 32'h0000_0304, $urandom, 3'b010);
        idle(0);
      end
      begin
        step(LAT + 3);
        issue(1, 1'b0, 32'h0000_0308, $urandom, 3'b010);
        issue(1, 1'b1, 32'h0000_030C, 32'hCAFE_F00D, 3'b010);
        idle(1);
        step(2);
        excl_req = 1'b0;
      end
    join
    step(LAT + 1);

    // reset while a load is in flight, then a tie
    issue(0, 1'b0, 32'h0000_0400, $urandom, 3'b010);
    idle(0);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(LAT + 2);
    fork
      begin issue(0, 1'b0, 32'h0000_0404, $urandom, 3'b010); idle(0); end
      begin issue(1, 1'b0, 32'h0000_0408, $urandom, 3'b010); idle(1); end
    join
    step(LAT + 1);

    // random traffic
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      g0 = gnt0;
      g1 = gnt1;
      @(posedge clk);
      #1;
      if (reset) reset = 1'b0;
      if (!req0 || g0) begin
        if ($urandom_range(0, 3) != 0)
          drive(0, 1'b1, 1'($urandom_range(0, 2) == 0), 32'h1000 + 32'($urandom_range(0, 15)) * 4,
                $urandom, 3'($urandom));
        else idle(0);
      end
      if (!req1 || g1) begin
        if ($urandom_range(0, 3) != 0)
          drive(1, 1'b1, 1'($urandom_range(0, 2) == 0), 32'h1000 + 32'($urandom_range(0, 15)) * 4,
                $urandom, 3'($urandom));
        else idle(1);
      end
      if ($urandom_range(0, 39) == 0) excl_req = ~excl_req;
      if ($urandom_range(0, 999) == 0) reset = 1'b1;
    end

    reset    = 1'b0;
    excl_req = 1'b0;
    idle(0);
    idle(1);
    step(LAT + 4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
